mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS core: sequences every instruction through fetch, decode, execute, memory and writeback and generates all datapath enables, mux selects, and the 2-bit `ALUOp` consumed by the ALU control decoder. It sits in `mips_top` between the instruction register opcode field and the datapath. It also drives a request/ready handshake to the unified instruction/data memory, stalling in memory states until the access completes.

---
 rtl/mips_multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables. Define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes in TRAP.
`timescale 1ns/1ps
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;

    logic memReqRaw, memWriteRaw, irWriteRaw, pcWriteRaw, branchRaw, regWriteRaw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (state_d == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_d     = FETCH;
        memReqRaw   = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        pcWriteRaw  = 1'b0;
        branchRaw   = 1'b0;
        regWriteRaw = 1'b0;
        IorD        = 1'b0;
        PCSrc       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;

        case (state_q)
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memReqRaw = 1'b1;
                IorD      = 1'b1;
                state_d   = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            MEMWR: begin
                memReqRaw   = 1'b1;
                memWriteRaw = 1'b1;
                IorD        = 1'b1;
                state_d     = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                RegDst      = 1'b1;
                regWriteRaw = 1'b1;
            end
            BEQEX: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b01;
                PCSrc     = 2'b01;
                branchRaw = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regWriteRaw = 1'b1;
            end
            JEX: begin
                PCSrc      = 2'b10;
                pcWriteRaw = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            // FETCH and every unreachable encoding share the fetch controls; only FETCH advances
            default: begin
                memReqRaw  = 1'b1;
                ALUSrcB    = 2'b01;
                irWriteRaw = mem_ready;
                pcWriteRaw = mem_ready;
                state_d    = (state_q == FETCH && mem_ready) ? DECODE : FETCH;
            end
        endcase
    end

    // Strobes are gated directly by reset so they drop without waiting for a clock edge
    assign mem_req  = memReqRaw   & reset_n;
    assign MemWrite = memWriteRaw & reset_n;
    assign IRWrite  = irWriteRaw  & reset_n;
    assign PCWrite  = pcWriteRaw  & reset_n;
    assign Branch   = branchRaw   & reset_n;
    assign RegWrite = regWriteRaw & reset_n;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a per-instruction step model predicts every
// cycle's control word; a separate monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       RegDst, MemtoReg, RegWrite;
    logic [3:0] state;
    logic       illegal_op;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic       branch;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic [3:0] st;
        logic       ill;
    } ctrl_t;

    ctrl_t expQ[$];
    int    path[$];
    int    curState;
    logic  illegalExp;
    int    vectors;
    int    miscompares;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .state      (state),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Control word each step of an instruction should present
    function automatic ctrl_t ctrlFor(input int s, input logic mr, input logic ill);
        ctrl_t c;
        c     = '0;
        c.st  = s[3:0];
        c.ill = ill;
        case (s)
            0:  begin c.memReq = 1; c.aluSrcB = 2'b01; c.irWrite = mr; c.pcWrite = mr; end
            1:  c.aluSrcB = 2'b11;
            2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            3:  begin c.memReq = 1; c.iorD = 1; end
            4:  begin c.memtoReg = 1; c.regWrite = 1; end
            5:  begin c.memReq = 1; c.iorD = 1; c.memWrite = 1; end
            6:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
            7:  begin c.regDst = 1; c.regWrite = 1; end
            8:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcSrc = 2'b01; c.branch = 1; end
            9:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            10: c.regWrite = 1;
            11: begin c.pcSrc = 2'b10; c.pcWrite = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic loadPath(input logic [5:0] op);
        path.delete();
        case (op)
            6'b100011: path = '{1, 2, 3, 4};
            6'b101011: path = '{1, 2, 5};
            6'b000000: path = '{1, 6, 7};
            6'b000100: path = '{1, 8};
            6'b001000: path = '{1, 9, 10};
            6'b000010: path = '{1, 11};
`ifdef MC_ILLEGAL_TRAP_EN
            default:   path = '{1, 12};
`else
            default:   path = '{1};
`endif
        endcase
    endtask

    // Memory steps (fetch, read, write) hold until mem_ready; trap holds forever
    task automatic applyCycle(input logic mr);
        mem_ready = mr;
        expQ.push_back(ctrlFor(curState, mr, illegalExp));
        @(posedge clk);
        #1;
        if (curState == 12) begin
        end else if ((curState == 0 || curState == 3 || curState == 5) && !mr) begin
        end else if (path.size() > 0) begin
            curState = path.pop_front();
        end else begin
            curState = 0;
        end
        if (curState == 12) illegalExp = 1'b1;
    endtask

    task automatic runInstr(input logic [5:0] op, input int stallPct, input int memStalls);
        int   cycles;
        int   stallsLeft;
        logic mr;
        cycles     = 0;
        stallsLeft = memStalls;
        opcode     = op;
        loadPath(op);
        do begin
            if (stallsLeft > 0 && (curState == 3 || curState == 5)) begin
                mr = 1'b0;
                stallsLeft--;
            end else if (stallPct > 0) begin
                mr = ($urandom_range(0, 99) >= stallPct);
            end else begin
                mr = 1'b1;
            end
            applyCycle(mr);
            cycles++;
        end while (!(curState == 0 && path.size() == 0) && curState != 12 && cycles < 100);
        if (cycles >= 100) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout op=%b: got %0d cycles, required fewer than 100", op, cycles);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with no scoreboard entry pending
    task automatic doReset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        checkOutput("rst state", {28'd0, state}, 32'd0);
        checkOutput("rst illegal_op", {31'd0, illegal_op}, 32'd0);
        checkOutput("rst mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst IRWrite", {31'd0, IRWrite}, 32'd0);
        checkOutput("rst PCWrite", {31'd0, PCWrite}, 32'd0);
        checkOutput("rst ALUSrcB", {30'd0, ALUSrcB}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        curState   = 0;
        illegalExp = 1'b0;
        path.delete();
    endtask

    // Monitor: compare the DUT against the oldest prediction each falling edge
    initial begin
        ctrl_t exp;
        ctrl_t act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                act = '{mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA,
                        ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, state, illegal_op};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL ctrl in state %0d: got %h expected %h", exp.st, act, exp);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        int         idx;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        clk         = 1'b0;
        reset_n     = 1'b1;
        mem_ready   = 1'b1;
        opcode      = 6'd0;
        curState    = 0;
        illegalExp  = 1'b0;
        vectors     = 0;
        miscompares = 0;

        @(posedge clk);
        #1;
        doReset();

        runInstr(6'b000000, 0, 0);
        runInstr(6'b100011, 0, 2);
        runInstr(6'b101011, 0, 0);
        runInstr(6'b000100, 0, 0);
        runInstr(6'b001000, 0, 0);
        runInstr(6'b000010, 0, 0);
        runInstr(6'b111111, 0, 0);
        if (curState == 12) begin
            repeat (4) applyCycle(1'($urandom_range(0, 1)));
            doReset();
        end
        runInstr(6'b000000, 20, 0);

        // Abort a store stalled in MEMWR with an asynchronous reset
        opcode = 6'b101011;
        loadPath(6'b101011);
        repeat (3) applyCycle(1'b1);
        mem_ready = 1'b0;
        #1;
        checkOutput("MEMWR MemWrite", {31'd0, MemWrite}, 32'd1);
        checkOutput("MEMWR mem_req", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort MemWrite", {31'd0, MemWrite}, 32'd0);
        checkOutput("abort mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("abort state", {28'd0, state}, 32'd0);
        doReset();

        repeat (60) begin
            idx = $urandom_range(0, 6);
            if (idx == 6) op = 6'($urandom_range(0, 63));
            else          op = ops[idx];
            runInstr(op, 30, 0);
            if (curState == 12) begin
                repeat (3) applyCycle(1'($urandom_range(0, 1)));
                doReset();
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
